// File: rtl/weight_loader_pkg.sv
// Shared definitions for the weight loader slice.
// Purpose: default geometry of the weight memory and the loader FSM encoding.
// Contents:
//   WL_KERNEL_WIDTH      bits per packed 3x3 kernel (9 x 8-bit weights)
//   WL_NUM_BANKS         number of weight banks, one per MAC
//   WL_KERNELS_PER_BANK  kernels written to each bank per load
//   WL_ADDR_WIDTH        bank address width
//   wl_state_e           loader FSM states
//   wl_load_bytes()      number of stream bytes making up one complete load
package weight_loader_pkg;

    localparam int WL_BYTE_WIDTH       = 8;
    localparam int WL_KERNEL_WIDTH     = 72;
    localparam int WL_NUM_BANKS        = 4;
    localparam int WL_KERNELS_PER_BANK = 3;
    localparam int WL_ADDR_WIDTH       = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } wl_state_e;

    // Every bank receives the same number of kernels, so one load is a fixed
    // number of bytes regardless of the base address.
    function automatic int wl_load_bytes(input int kernelWidth,
                                         input int numBanks,
                                         input int kernelsPerBank);
        return (kernelWidth / WL_BYTE_WIDTH) * numBanks * kernelsPerBank;
    endfunction

endpackage

// File: rtl/weight_loader_kernel_packer.sv
// kernel_packer: assembles a stream of weight bytes into packed kernels.
// The first byte of a kernel ends up in the most significant byte.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   clear_i         restart packing at byte 0 (new load)
//   valid_i         a byte is accepted this cycle
//   data_i          the accepted byte
//   kernel_o        packed kernel, meaningful when kernelValid_o is high
//   kernelValid_o   high in the cycle the last byte of a kernel is accepted
module kernel_packer
    import weight_loader_pkg::*;
#(
    parameter int KERNEL_WIDTH = WL_KERNEL_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_i,
    input  logic                    valid_i,
    input  logic [7:0]              data_i,
    output logic [KERNEL_WIDTH-1:0] kernel_o,
    output logic                    kernelValid_o
);

    localparam int BYTES_PER_KERNEL = KERNEL_WIDTH / WL_BYTE_WIDTH;
    localparam int CNT_W            = $clog2(BYTES_PER_KERNEL);
    localparam int SHIFT_W          = KERNEL_WIDTH - WL_BYTE_WIDTH;

    logic [CNT_W-1:0]   byteCnt_q, byteCnt_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic               lastByte;

    assign lastByte = (byteCnt_q == CNT_W'(BYTES_PER_KERNEL - 1));

    // Only the first eight bytes are stored; the ninth is taken straight from
    // the input so the full kernel is available in the cycle it arrives and
    // the top level can register the write one cycle later.
    always_comb begin
        byteCnt_d     = byteCnt_q;
        shift_d       = shift_q;
        kernelValid_o = 1'b0;
        kernel_o      = {shift_q, data_i};
        if (clear_i) begin
            byteCnt_d = '0;
        end else if (valid_i) begin
            shift_d = {shift_q[SHIFT_W-WL_BYTE_WIDTH-1:0], data_i};
            if (lastByte) begin
                byteCnt_d     = '0;
                kernelValid_o = 1'b1;
            end else begin
                byteCnt_d = byteCnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byteCnt_q <= '0;
            shift_q   <= '0;
        end else begin
            byteCnt_q <= byteCnt_d;
            shift_q   <= shift_d;
        end
    end

endmodule

// File: rtl/weight_loader.sv
// weight_loader: streams weight bytes into packed 3x3 kernels and writes them
// round-robin across the weight banks, one kernel per bank per address row.
// Ports:
//   clk, rst                      clock and asynchronous active-high reset
//   i_start, i_base_addr          load request and first bank address
//   i_s_tdata/tvalid/tlast,
//   o_s_tready                    byte stream in (ready only while filling)
//   o_wr_en, o_wr_addr, o_wr_data one-hot bank write port
//   o_busy, o_done, o_err         status: active, completion pulse, framing error
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter int KERNEL_WIDTH     = WL_KERNEL_WIDTH,
    parameter int NUM_BANKS        = WL_NUM_BANKS,
    parameter int KERNELS_PER_BANK = WL_KERNELS_PER_BANK,
    parameter int ADDR_WIDTH       = WL_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic [ADDR_WIDTH-1:0]   i_base_addr,
    input  logic [7:0]              i_s_tdata,
    input  logic                    i_s_tvalid,
    output logic                    o_s_tready,
    input  logic                    i_s_tlast,
    output logic [NUM_BANKS-1:0]    o_wr_en,
    output logic [ADDR_WIDTH-1:0]   o_wr_addr,
    output logic [KERNEL_WIDTH-1:0] o_wr_data,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err
);

    localparam int LOAD_BYTES = wl_load_bytes(KERNEL_WIDTH, NUM_BANKS, KERNELS_PER_BANK);
    localparam int BCNT_W     = $clog2(LOAD_BYTES + 1);
    localparam int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    wl_state_e               state_q, state_d;
    logic [BCNT_W-1:0]       byteCnt_q, byteCnt_d;
    logic [BANK_W-1:0]       bankSel_q, bankSel_d;
    logic [ADDR_WIDTH-1:0]   rowAddr_q, rowAddr_d;
    logic                    err_q, err_d;
    logic [NUM_BANKS-1:0]    wrEn_q, wrEn_d;
    logic [ADDR_WIDTH-1:0]   wrAddr_q, wrAddr_d;
    logic [KERNEL_WIDTH-1:0] wrData_q, wrData_d;

    logic                    startAccept;
    logic                    byteAccept;
    logic                    finalByte;
    logic [KERNEL_WIDTH-1:0] packedKernel;
    logic                    kernelValid;

    assign startAccept = (state_q == ST_IDLE) && i_start;
    assign byteAccept  = (state_q == ST_FILL) && i_s_tvalid;
    assign finalByte   = (byteCnt_q == BCNT_W'(LOAD_BYTES - 1));

    kernel_packer #(
        .KERNEL_WIDTH(KERNEL_WIDTH)
    ) u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (startAccept),
        .valid_i      (byteAccept),
        .data_i       (i_s_tdata),
        .kernel_o     (packedKernel),
        .kernelValid_o(kernelValid)
    );

    // Load sequencing and framing checks. A tlast before the final byte
    // aborts straight back to IDLE; any partially packed kernel is simply
    // abandoned because the packer is cleared on the next accepted start.
    always_comb begin
        state_d   = state_q;
        byteCnt_d = byteCnt_q;
        bankSel_d = bankSel_q;
        rowAddr_d = rowAddr_q;
        err_d     = err_q;
        wrEn_d    = '0;
        wrAddr_d  = wrAddr_q;
        wrData_d  = wrData_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d   = ST_FILL;
                    byteCnt_d = '0;
                    bankSel_d = '0;
                    rowAddr_d = i_base_addr;
                    err_d     = 1'b0;
                end
            end
            ST_FILL: begin
                if (byteAccept) begin
                    byteCnt_d = byteCnt_q + BCNT_W'(1);
                    if (finalByte) begin
                        state_d = ST_DONE;
                        if (!i_s_tlast) begin
                            err_d = 1'b1;
                        end
                    end else if (i_s_tlast) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Kernels rotate across banks; the row address only advances once
        // every bank has received a kernel, wrapping at the top of the bank.
        if (kernelValid) begin
            wrEn_d   = NUM_BANKS'(1) << bankSel_q;
            wrAddr_d = rowAddr_q;
            wrData_d = packedKernel;
            if (bankSel_q == BANK_W'(NUM_BANKS - 1)) begin
                bankSel_d = '0;
                rowAddr_d = rowAddr_q + ADDR_WIDTH'(1);
            end else begin
                bankSel_d = bankSel_q + BANK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            byteCnt_q <= '0;
            bankSel_q <= '0;
            rowAddr_q <= '0;
            err_q     <= 1'b0;
            wrEn_q    <= '0;
            wrAddr_q  <= '0;
            wrData_q  <= '0;
        end else begin
            state_q   <= state_d;
            byteCnt_q <= byteCnt_d;
            bankSel_q <= bankSel_d;
            rowAddr_q <= rowAddr_d;
            err_q     <= err_d;
            wrEn_q    <= wrEn_d;
            wrAddr_q  <= wrAddr_d;
            wrData_q  <= wrData_d;
        end
    end

    assign o_s_tready = (state_q == ST_FILL);
    assign o_busy     = (state_q != ST_IDLE);
    assign o_done     = (state_q == ST_DONE);
    assign o_err      = err_q;
    assign o_wr_en    = wrEn_q;
    assign o_wr_addr  = wrAddr_q;
    assign o_wr_data  = wrData_q;

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader: randomised byte streams checked
// against a kernel/bank/address model built directly from the load rules.
module tb_weight_loader;

    localparam int KW     = 72;
    localparam int NB     = 4;
    localparam int KPB    = 3;
    localparam int AW     = 10;
    localparam int NK     = NB * KPB;
    localparam int NBYTES = 9 * NK;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [AW-1:0] i_base_addr;
    logic [7:0]    i_s_tdata;
    logic          i_s_tvalid;
    logic          o_s_tready;
    logic          i_s_tlast;
    logic [NB-1:0] o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic [KW-1:0] o_wr_data;
    logic          o_busy;
    logic          o_done;
    logic          o_err;

    always #5 clk = ~clk;

    weight_loader dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_base_addr(i_base_addr),
        .i_s_tdata  (i_s_tdata),
        .i_s_tvalid (i_s_tvalid),
        .o_s_tready (o_s_tready),
        .i_s_tlast  (i_s_tlast),
        .o_wr_en    (o_wr_en),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0]    stim [NBYTES];
    logic [NB-1:0] wrEnQ[$];
    logic [AW-1:0] wrAddrQ[$];
    logic [KW-1:0] wrDataQ[$];
    int            doneCnt;
    int            doneWithFinal;

    // Write/done monitor, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (o_wr_en != '0) begin
            wrEnQ.push_back(o_wr_en);
            wrAddrQ.push_back(o_wr_addr);
            wrDataQ.push_back(o_wr_data);
        end
        if (o_done === 1'b1) begin
            doneCnt++;
            if (o_wr_en === (NB'(1) << ((NK - 1) % NB))) doneWithFinal++;
        end
    end

    // Reference model: kernel k is bytes 9k..9k+8, first byte most significant,
    // written to bank k mod NB at row base + k div NB (mod 2^AW).
    function automatic logic [KW-1:0] expKernel(input int k);
        logic [KW-1:0] d = '0;
        for (int j = 0; j < 9; j++) d = {d[KW-9:0], stim[9*k+j]};
        return d;
    endfunction

    function automatic logic [AW-1:0] expAddr(input logic [AW-1:0] base, input int k);
        return AW'((int'(base) + k / NB) % (1 << AW));
    endfunction

    function automatic logic [NB-1:0] expBank(input int k);
        return NB'(1) << (k % NB);
    endfunction

    task automatic clear_log();
        wrEnQ.delete();
        wrAddrQ.delete();
        wrDataQ.delete();
        doneCnt       = 0;
        doneWithFinal = 0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NBYTES; i++) stim[i] = 8'($urandom);
    endtask

    task automatic start_load(input logic [AW-1:0] base);
        @(posedge clk); #1;
        i_start     = 1'b1;
        i_base_addr = base;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    // Streams n bytes from stim; tlast rides on byte number tlastAt (1-based,
    // 0 = never). With injectAt > 0, i_start is raised while byte injectAt is
    // being offered to prove starts are ignored mid-load.
    task automatic stream_bytes(input int n, input int tlastAt, input bit gaps, input int injectAt);
        int idx = 0;
        int cyc = 0;
        bit v;
        bit accepted;
        while (idx < n && cyc < 4000) begin
            v          = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            i_s_tvalid = v;
            i_s_tdata  = stim[idx];
            i_s_tlast  = (idx + 1 == tlastAt);
            i_start    = (injectAt > 0) && (idx == injectAt);
            if (i_start) i_base_addr = 10'h155;
            accepted   = v && (o_s_tready === 1'b1);
            @(posedge clk);
            cyc++;
            if (accepted) idx++;
            #1;
        end
        i_s_tvalid = 1'b0;
        i_s_tlast  = 1'b0;
        i_start    = 1'b0;
        checks++;
        if (idx != n) begin
            failures++;
            $display("[TB] FAIL stream_accept bytes_accepted=%0d required=%0d", idx, n);
        end
    endtask

    task automatic flush();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if ({o_s_tready, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_err} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got tready=%b en=%b addr=%h data=%h busy=%b done=%b err=%b required all zero",
                     o_s_tready, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_err);
        end
        #9 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (o_busy !== 1'b0 || o_s_tready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_idle got busy=%b tready=%b required 0 0", o_busy, o_s_tready);
        end
    endtask

    task automatic test_full_load(input string name, input logic [AW-1:0] base,
                                  input bit gaps, input bit randomData, input bit withTlast);
        if (randomData) fill_random();
        else for (int i = 0; i < NBYTES; i++) stim[i] = 8'(i);
        clear_log();
        start_load(base);
        stream_bytes(NBYTES, withTlast ? NBYTES : 0, gaps, 0);
        flush();
        checks++;
        if (wrEnQ.size() != NK) begin
            failures++;
            $display("[TB] FAIL %s_write_count got=%0d required=%0d", name, wrEnQ.size(), NK);
        end
        for (int k = 0; k < NK && k < wrEnQ.size(); k++) begin
            checks++;
            if ({wrEnQ[k], wrAddrQ[k], wrDataQ[k]} !== {expBank(k), expAddr(base, k), expKernel(k)}) begin
                failures++;
                $display("[TB] FAIL %s_write%0d got en=%b addr=%h data=%h required en=%b addr=%h data=%h",
                         name, k, wrEnQ[k], wrAddrQ[k], wrDataQ[k], expBank(k), expAddr(base, k), expKernel(k));
            end
        end
        checks++;
        if (doneCnt != 1 || doneWithFinal != 1) begin
            failures++;
            $display("[TB] FAIL %s_done got pulses=%0d with_final_write=%0d required 1 1", name, doneCnt, doneWithFinal);
        end
        checks++;
        if (o_err !== !withTlast || o_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_status got err=%b busy=%b required err=%b busy=0", name, o_err, o_busy, !withTlast);
        end
    endtask

    task automatic test_nominal();
        test_full_load("nominal", 10'h000, 1'b0, 1'b0, 1'b1);
        checks++;
        if (wrDataQ.size() < 1 || wrDataQ[0] !== 72'h000102030405060708) begin
            failures++;
            $display("[TB] FAIL nominal_kernel0 got=%h required=000102030405060708",
                     wrDataQ.size() > 0 ? wrDataQ[0] : 72'h0);
        end
    endtask

    task automatic test_gaps();
        test_full_load("gaps", 10'h000, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_wrap();
        test_full_load("wrap", 10'h3FF, 1'b1, 1'b1, 1'b1);
        checks++;
        if (wrAddrQ.size() < NK || wrAddrQ[3] !== 10'h3FF || wrAddrQ[4] !== 10'h000 || wrAddrQ[8] !== 10'h001) begin
            failures++;
            $display("[TB] FAIL wrap_rows got size=%0d required rows 3FF/000/001 at kernels 3/4/8", wrAddrQ.size());
        end
    endtask

    task automatic test_missing_tlast();
        test_full_load("missing_tlast", 10'h1A0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_early_tlast();
        fill_random();
        clear_log();
        start_load(10'h040);
        stream_bytes(20, 20, 1'b0, 0);
        flush();
        checks++;
        if (wrEnQ.size() != 2) begin
            failures++;
            $display("[TB] FAIL early_write_count got=%0d required=2", wrEnQ.size());
        end
        for (int k = 0; k < 2 && k < wrEnQ.size(); k++) begin
            checks++;
            if ({wrEnQ[k], wrAddrQ[k], wrDataQ[k]} !== {expBank(k), expAddr(10'h040, k), expKernel(k)}) begin
                failures++;
                $display("[TB] FAIL early_write%0d got en=%b addr=%h data=%h required en=%b addr=%h data=%h",
                         k, wrEnQ[k], wrAddrQ[k], wrDataQ[k], expBank(k), expAddr(10'h040, k), expKernel(k));
            end
        end
        checks++;
        if (doneCnt != 0 || o_err !== 1'b1 || o_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL early_status got done=%0d err=%b busy=%b required 0 1 0", doneCnt, o_err, o_busy);
        end
        start_load(10'h000);
        checks++;
        if (o_err !== 1'b0 || o_busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL early_err_clear got err=%b busy=%b required 0 1", o_err, o_busy);
        end
        stream_bytes(NBYTES, NBYTES, 1'b0, 0);
        flush();
    endtask

    task automatic test_reset_midload();
        fill_random();
        clear_log();
        start_load(10'h020);
        stream_bytes(50, 0, 1'b0, 30);
        rst = 1'b1;
        #1;
        checks++;
        if ({o_s_tready, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_err} !== '0) begin
            failures++;
            $display("[TB] FAIL midload_reset_outputs got tready=%b en=%b addr=%h busy=%b done=%b err=%b required all zero",
                     o_s_tready, o_wr_en, o_wr_addr, o_busy, o_done, o_err);
        end
        checks++;
        if (wrEnQ.size() != 5) begin
            failures++;
            $display("[TB] FAIL midload_write_count got=%0d required=5", wrEnQ.size());
        end
        for (int k = 0; k < 5 && k < wrEnQ.size(); k++) begin
            checks++;
            if ({wrEnQ[k], wrAddrQ[k], wrDataQ[k]} !== {expBank(k), expAddr(10'h020, k), expKernel(k)}) begin
                failures++;
                $display("[TB] FAIL midload_write%0d got en=%b addr=%h data=%h required en=%b addr=%h data=%h",
                         k, wrEnQ[k], wrAddrQ[k], wrDataQ[k], expBank(k), expAddr(10'h020, k), expKernel(k));
            end
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        i_s_tvalid = 1'b1;
        repeat (30) @(posedge clk);
        #1 i_s_tvalid = 1'b0;
        checks++;
        if (wrEnQ.size() != 5 || o_busy !== 1'b0 || doneCnt != 0) begin
            failures++;
            $display("[TB] FAIL midload_after_reset got writes=%0d busy=%b done=%0d required 5 0 0",
                     wrEnQ.size(), o_busy, doneCnt);
        end
    endtask

    initial begin
        rst         = 1'b1;
        i_start     = 1'b0;
        i_base_addr = '0;
        i_s_tdata   = '0;
        i_s_tvalid  = 1'b0;
        i_s_tlast   = 1'b0;
        test_reset();
        test_nominal();
        test_gaps();
        test_wrap();
        test_early_tlast();
        test_missing_tlast();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
